// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode, ALU and field constants plus decode helpers for the 16-bit ISA
package isa_pkg;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RS_MSB = 11;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 0;
    localparam int JT_MSB = 11;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [2:0] r;
        case (op)
            OP_SUB, OP_BEQ: r = ALU_SUB;
            OP_AND:         r = ALU_AND;
            OP_OR:          r = ALU_OR;
            OP_SLT:         r = ALU_SLT;
            default:        r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sign_ext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with increment/branch/jump next-PC mux
module pc_unit
    import isa_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           pc_sel,
    input  logic              zero,
    input  logic [15:0]       imm_ext,
    input  logic [11:0]       jump_target,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;

    // Sums are taken modulo 2^ADDR_W, so 16'hFFFF+1 wraps to 0; ADDR_W is 13..16.
    always_comb begin
        pc_inc  = pc + ONE;
        pc_next = pc;
        case (pc_sel)
            PC_INC:    pc_next = pc_inc;
            PC_BRANCH: pc_next = zero ? (pc_inc + imm_ext[ADDR_W-1:0]) : pc_inc;
            PC_JUMP:   pc_next = {pc[ADDR_W-1:12], jump_target};
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/decode_control_fsm.sv
// rtl/decode_control_fsm.sv - multi-cycle decode/control sequencer; ILLEGAL_TRAP_EN traps opcodes A-E
module decode_control_fsm
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr_data,
    output logic              instr_ready,
    input  logic              zero,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        select1,
    output logic [3:0]        select2,
    output logic [3:0]        select3,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src,
    output logic [2:0]        alu_op,
    output logic [15:0]       imm_ext,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
`ifdef ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic              halted
);

    state_t      state;
    state_t      next_state;
    pc_sel_t     pc_sel;
    logic [15:0] ir;
    logic [3:0]  op;

    assign op = ir[OP_MSB:OP_LSB];

    always_comb begin
        next_state = state;
        pc_sel     = PC_HOLD;
        case (state)
            ST_FETCH: begin
                if (instr_valid && instr_ready) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                pc_sel = PC_INC;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: next_state = ST_WB;
                    OP_LW, OP_SW: next_state = ST_MEM;
                    OP_BEQ: begin
                        pc_sel     = PC_BRANCH;
                        next_state = ST_FETCH;
                    end
                    OP_J: begin
                        pc_sel     = PC_JUMP;
                        next_state = ST_FETCH;
                    end
                    OP_HALT: next_state = ST_HALT;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        pc_sel     = PC_HOLD;
                        next_state = ST_HALT;
`else
                        next_state = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    next_state = (op == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   next_state = ST_FETCH;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_FETCH;
        endcase
    end

    // Strobes are registered from next_state so each one lines up exactly with its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            ir          <= '0;
            instr_ready <= 1'b1;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            halted      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            state       <= next_state;
            if (instr_valid && instr_ready) begin
                ir <= instr_data;
            end
            instr_ready <= (next_state == ST_FETCH);
            reg_write   <= (next_state == ST_WB);
            mem_read    <= (next_state == ST_MEM) && (op == OP_LW);
            mem_write   <= (next_state == ST_MEM) && (op == OP_SW);
            halted      <= (next_state == ST_HALT);
`ifdef ILLEGAL_TRAP_EN
            illegal     <= (next_state == ST_HALT) && is_illegal(op);
`endif
        end
    end

    // Decoded fields are captured once per instruction and held through the following FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            select1    <= '0;
            select2    <= '0;
            select3    <= '0;
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= ALU_ADD;
            imm_ext    <= '0;
            mem_to_reg <= 1'b0;
        end else if (state == ST_DECODE) begin
            select1    <= ir[RS_MSB:RS_LSB];
            select2    <= ir[RT_MSB:RT_LSB];
            select3    <= ir[RD_MSB:RD_LSB];
            reg_dst    <= is_rtype(op);
            alu_src    <= is_imm_op(op);
            alu_op     <= alu_op_of(op);
            imm_ext    <= sign_ext4(ir[RD_MSB:RD_LSB]);
            mem_to_reg <= (op == OP_LW);
        end
    end

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .zero        (zero),
        .imm_ext     (imm_ext),
        .jump_target (ir[JT_MSB:0]),
        .pc          (pc_out)
    );

endmodule

// File: tb/tb_decode_control_fsm.sv
// tb/tb_decode_control_fsm.sv - randomized bench for decode_control_fsm with per-cycle reference model
module tb_decode_control_fsm;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  s3;
        logic        reg_dst;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic [15:0] imm;
        logic        mem_to_reg;
    } dec_t;

    typedef struct packed {
        logic        ready;
        logic [15:0] pc;
        dec_t        dec;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        halted;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic        zero;
    logic        mem_ack;
    logic [15:0] pc_out;
    logic [3:0]  select1, select2, select3;
    logic        reg_dst, reg_write, alu_src;
    logic [2:0]  alu_op;
    logic [15:0] imm_ext;
    logic        mem_read, mem_write, mem_to_reg, halted;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;
    exp_t exp_now;

    logic [15:0] m_pc;
    dec_t        m_dec;
    logic        m_halt;
    logic        m_ill;

    decode_control_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .pc_out      (pc_out),
        .select1     (select1),
        .select2     (select2),
        .select3     (select3),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .imm_ext     (imm_ext),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
`ifdef ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", 32'(instr_ready), 32'(exp_now.ready));
            chk("pc_out", 32'(pc_out), 32'(exp_now.pc));
            chk("select1", 32'(select1), 32'(exp_now.dec.s1));
            chk("select2", 32'(select2), 32'(exp_now.dec.s2));
            chk("select3", 32'(select3), 32'(exp_now.dec.s3));
            chk("reg_dst", 32'(reg_dst), 32'(exp_now.dec.reg_dst));
            chk("alu_src", 32'(alu_src), 32'(exp_now.dec.alu_src));
            chk("alu_op", 32'(alu_op), 32'(exp_now.dec.alu_op));
            chk("imm_ext", 32'(imm_ext), 32'(exp_now.dec.imm));
            chk("mem_to_reg", 32'(mem_to_reg), 32'(exp_now.dec.mem_to_reg));
            chk("reg_write", 32'(reg_write), 32'(exp_now.rw));
            chk("mem_read", 32'(mem_read), 32'(exp_now.mr));
            chk("mem_write", 32'(mem_write), 32'(exp_now.mw));
            chk("halted", 32'(halted), 32'(exp_now.halted));
`ifdef ILLEGAL_TRAP_EN
            chk("illegal", 32'(illegal), 32'(exp_now.illegal));
`endif
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] r16();
        return 16'($urandom);
    endfunction

    function automatic dec_t decode(input logic [15:0] i);
        dec_t       d;
        logic [3:0] op;
        op           = i[15:12];
        d.s1         = i[11:8];
        d.s2         = i[7:4];
        d.s3         = i[3:0];
        d.imm        = {{12{i[3]}}, i[3:0]};
        d.reg_dst    = (op < 4'd5);
        d.alu_src    = (op >= 4'd5) && (op <= 4'd7);
        d.mem_to_reg = (op == 4'd6);
        d.alu_op     = (op < 4'd5) ? op[2:0] : ((op == 4'd8) ? 3'd1 : 3'd0);
        return d;
    endfunction

    function automatic exp_t base();
        exp_t e;
        e.ready   = 1'b0;
        e.pc      = m_pc;
        e.dec     = m_dec;
        e.rw      = 1'b0;
        e.mr      = 1'b0;
        e.mw      = 1'b0;
        e.halted  = m_halt;
        e.illegal = m_ill;
        return e;
    endfunction

    task automatic step(input logic v, input logic [15:0] d, input logic z, input logic a,
                        input logic r, input exp_t e);
        instr_valid = v;
        instr_data  = d;
        zero        = z;
        mem_ack     = a;
        rst_n       = r;
        @(posedge clk);
        #1;
        exp_now = e;
        chk_en  = 1'b1;
    endtask

    task automatic do_reset();
        exp_t e;
        m_pc   = 16'h0000;
        m_dec  = '0;
        m_halt = 1'b0;
        m_ill  = 1'b0;
        e       = base();
        e.ready = 1'b1;
        step(rb(), r16(), rb(), rb(), 1'b0, e);
    endtask

    // Runs one instruction from FETCH; k = MEM cycles before ack, abort = MEM cycle that sees reset.
    task automatic run_instr(input logic [15:0] ins, input int k, input logic z, input int abort);
        exp_t       e;
        logic [3:0] op;
        bit         halting;
        int         idle;
        op      = ins[15:12];
        halting = (op == 4'hF) || (TRAP && op >= 4'hA && op <= 4'hE);
        idle    = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            e       = base();
            e.ready = 1'b1;
            step(1'b0, r16(), rb(), rb(), 1'b1, e);
        end
        e = base();
        step(1'b1, ins, rb(), rb(), 1'b1, e);
        m_dec = decode(ins);
        e = base();
        step(rb(), r16(), rb(), rb(), 1'b1, e);

        if (TRAP && op >= 4'hA && op <= 4'hE) begin
            m_halt = 1'b1;
            m_ill  = 1'b1;
        end else if (op == 4'h8) begin
            m_pc = m_pc + 16'd1 + (z ? m_dec.imm : 16'd0);
        end else if (op == 4'h9) begin
            m_pc = {m_pc[15:12], ins[11:0]};
        end else begin
            m_pc = m_pc + 16'd1;
            if (op == 4'hF) m_halt = 1'b1;
        end

        e = base();
        if (halting) begin
            step(rb(), r16(), z, rb(), 1'b1, e);
            for (int i = 0; i < 3; i++) step(1'b1, r16(), rb(), rb(), 1'b1, e);
        end else if (op == 4'h6 || op == 4'h7) begin
            e.mr = (op == 4'h6);
            e.mw = (op == 4'h7);
            step(rb(), r16(), z, rb(), 1'b1, e);
            for (int j = 1; j <= k; j++) begin
                if (abort > 0 && j == abort) begin
                    do_reset();
                    return;
                end
                if (j < k) begin
                    step(rb(), r16(), rb(), 1'b0, 1'b1, e);
                end else begin
                    e = base();
                    if (op == 4'h6) e.rw = 1'b1;
                    else            e.ready = 1'b1;
                    step(rb(), r16(), rb(), 1'b1, 1'b1, e);
                    if (op == 4'h6) begin
                        e       = base();
                        e.ready = 1'b1;
                        step(rb(), r16(), rb(), rb(), 1'b1, e);
                    end
                end
            end
        end else if (op <= 4'h5) begin
            e.rw = 1'b1;
            step(rb(), r16(), z, rb(), 1'b1, e);
            e       = base();
            e.ready = 1'b1;
            step(rb(), r16(), rb(), rb(), 1'b1, e);
        end else begin
            e.ready = 1'b1;
            step(rb(), r16(), z, rb(), 1'b1, e);
        end
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        int          k;
        int          ab;

        instr_valid = 1'b0;
        instr_data  = '0;
        zero        = 1'b0;
        mem_ack     = 1'b0;
        rst_n       = 1'b0;
        do_reset();
        do_reset();

        // ADD r3 = r1 + r2
        run_instr(16'h0123, 1, 1'b0, 0);
        chk("add_pc", 32'(pc_out), 32'h0001);
        chk("add_sel1", 32'(select1), 32'd1);
        chk("add_sel2", 32'(select2), 32'd2);
        chk("add_sel3", 32'(select3), 32'd3);
        chk("add_regdst", 32'(reg_dst), 32'd1);

        // LW with ack in the third MEM cycle
        do_reset();
        run_instr(16'h6215, 3, 1'b0, 0);
        chk("lw_pc", 32'(pc_out), 32'h0001);
        chk("lw_memtoreg", 32'(mem_to_reg), 32'd1);
        chk("lw_sel2", 32'(select2), 32'd1);
        chk("lw_regdst", 32'(reg_dst), 32'd0);

        // BEQ at pc=5, taken and not taken
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(16'h0123, 1, 1'b0, 0);
        run_instr(16'h812E, 1, 1'b1, 0);
        chk("beq_taken_pc", 32'(pc_out), 32'h0004);
        run_instr(16'h0000, 1, 1'b0, 0);
        run_instr(16'h812E, 1, 1'b0, 0);
        chk("beq_not_taken_pc", 32'(pc_out), 32'h0006);

        // Climb to 3FFF with jumps and increments, then jump within the page
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_instr(16'h9FFF, 1, 1'b0, 0);
            run_instr(16'h5001, 1, 1'b0, 0);
        end
        run_instr(16'h9FFF, 1, 1'b0, 0);
        chk("climb_pc", 32'(pc_out), 32'h3FFF);
        run_instr(16'h9ABC, 1, 1'b0, 0);
        chk("j_pc", 32'(pc_out), 32'h3ABC);

        // Wrap: 0 + 1 - 2 = FFFF, then ADD wraps to 0
        do_reset();
        run_instr(16'h800E, 1, 1'b1, 0);
        chk("neg_branch_pc", 32'(pc_out), 32'hFFFF);
        run_instr(16'h0456, 1, 1'b0, 0);
        chk("wrap_pc", 32'(pc_out), 32'h0000);

        // Reset while a load is waiting for ack
        run_instr(16'h0123, 1, 1'b0, 0);
        run_instr(16'h6215, 5, 1'b0, 3);
        chk("rst_mem_pc", 32'(pc_out), 32'h0000);
        chk("rst_mem_ready", 32'(instr_ready), 32'd1);
        chk("rst_mem_read", 32'(mem_read), 32'd0);

        // Illegal opcode and HALT
        run_instr(16'hB000, 1, 1'b0, 0);
        chk("illegal_halted", 32'(halted), 32'(TRAP));
        chk("illegal_ready", 32'(instr_ready), 32'(!TRAP));
        chk("illegal_pc", 32'(pc_out), TRAP ? 32'h0000 : 32'h0001);
        do_reset();
        run_instr(16'hF000, 1, 1'b0, 0);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_ready", 32'(instr_ready), 32'd0);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            ins = r16();
            op  = ins[15:12];
            if (op >= 4'hA && $urandom_range(0, 3) != 0) ins[15:12] = 4'(op - 4'h8);
            k  = $urandom_range(1, 4);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, k) : 0;
            run_instr(ins, k, rb(), ab);
            if (m_halt) do_reset();
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_control_fsm.md
Name: decode_control_fsm

Overview:
- Multi-cycle instruction decode and control sequencer for the 16-bit ISA.
- Sits directly upstream of the register file. Accepts instructions from the fetch buffer over a valid/ready handshake and latches them.
- Drives the register-file selects (rs/rt/rd), RegDst and a single-cycle RegWrite strobe, plus ALU and data-memory control.
- Owns the program counter.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset
- ADDR_W, 16, PC width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  fetch buffer holds a valid instruction
- instr_data  in  16  instruction word {op[15:12], rs[11:8], rt[7:4], rd_imm[3:0]}
- instr_ready  out  1  sequencer accepts an instruction this cycle
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ack  in  1  data memory access complete
- pc_out  out  ADDR_W  current PC
- select1  out  4  rs to register file
- select2  out  4  rt to register file
- select3  out  4  rd to register file
- reg_dst  out  1  1 = write rd, 0 = write rt
- reg_write  out  1  register-file write strobe
- alu_src  out  1  1 = immediate operand
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- imm_ext  out  16  sign-extended rd_imm
- mem_read  out  1  load request
- mem_write  out  1  store request
- mem_to_reg  out  1  writeback source = memory
- halted  out  1  HALT executed

Behaviour:
- Reset (rst_n low at a clk edge): state=FETCH, pc=PC_RESET, IR=0. All control outputs, select*, imm_ext, halted = 0. Applies from any state, including mid-MEM wait.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - instr_ready=1 only in this state.
  - Handshake when instr_valid&&instr_ready: IR<=instr_data, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Register select1=rs, select2=rt, select3=rd, imm_ext, reg_dst, alu_src, alu_op, mem_to_reg from IR.
  - These outputs hold stable until the next FETCH.
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT: R-type, reg_dst=1.
  - 5 ADDI, 6 LW, 7 SW: alu_src=1, reg_dst=0.
  - 8 BEQ (ALU SUB, compare rs/rt).
  - 9 J: target = IR[11:0].
  - F HALT.
  - A–E illegal.
- EXEC: PC update.
  - Default: pc<=pc+1, word addressing, wraps 16'hFFFF->0.
  - BEQ with zero=1: pc<=pc+1+imm_ext (modulo 2^16).
  - J: pc<={pc[15:12], IR[11:0]}.
  - Next state: LW/SW -> MEM; R-type/ADDI -> WB; BEQ/J/illegal -> FETCH; HALT -> HALT.
- MEM:
  - mem_read (LW) or mem_write (SW) held high until the cycle mem_ack=1.
  - On ack: LW -> WB, SW -> FETCH. No timeout.
- WB: reg_write=1 for exactly this one cycle, then FETCH.
- reg_write is never high outside WB.
- HALT: halted=1, instr_ready=0, remains until reset.
- Cycle counts from handshake edge to the next instr_ready:
  - R-type/ADDI: 3 cycles.
  - BEQ/J: 2 cycles.
  - LW: 3 cycles + MEM wait (≥1).
- All outputs are registered.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit). Opcodes A–E go to HALT with illegal=1 and halted=1; pc is not advanced.
- Undefined: opcodes A–E execute as NOP (pc+1, no write, back to FETCH). No illegal port.

Decomposition:
- Package isa_pkg: opcode constants OP_ADD..OP_HALT, ALU op codes, state enum, field-slice constants (OP_MSB etc.).
- Optional sub-module pc_unit: PC register and next-PC mux (inc/branch/jump, wrap). Inputs: state-derived selects, imm_ext, IR[11:0], zero.

Test Plan:
- Reset, then instr_valid=1 with 16'h0123 (ADD r3=r1+r2) -> select1=1, select2=2, select3=3, reg_dst=1, alu_op=0; reg_write pulses one cycle 3 cycles after handshake; pc 0->1.
- LW 16'h6215 with mem_ack delayed 3 cycles -> mem_read high 3 cycles; WB with mem_to_reg=1, reg_dst=0, select2=1; pc=1.
- BEQ 16'h812E at pc=5, zero=1 -> pc=4 (5+1-2). With zero=0 -> pc=6. reg_write never asserted.
- J 16'h9ABC at pc=16'h3FFF -> pc=16'h3ABC. Separately, pc=16'hFFFF plus ADD -> pc wraps to 0.
- rst_n low during MEM wait (mem_read=1) -> next edge: state FETCH, pc=0, mem_read=0, instr_ready=1.
- Opcode 16'hB000 -> with ILLEGAL_TRAP_EN: halted=1, illegal=1, instr_ready stays 0. Without: pc+1, back to FETCH. HALT 16'hF000 -> halted=1 until reset.
